// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple adder controller: feeds one operand bit pair per clock, LSB first, through a single adder cell.
// Latency: start accepted at edge 0, result and done_out at edge WIDTH, back in IDLE after edge WIDTH+1.
// Backpressure: none; start_in is ignored while busy_out is high and is not queued.
//
// Ports:
//   clk_in     rising-edge clock
//   rst_n_in   asynchronous active-low reset, clears all state and outputs
//   start_in   request, sampled only in IDLE
//   a_in/b_in  operands, captured with cin_in on an accepted start
//   busy_out   high in SHIFT and DONE (registered)
//   done_out   one-cycle pulse when sum_out/carry_out have just been loaded
//   sum_out    result, held until the next completion
//   carry_out  final carry, held until the next completion
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out
);

   // One extra bit over clog2 keeps WIDTH-1 representable for every legal WIDTH.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] a_sh, a_sh_nxt;
   logic [WIDTH-1:0] b_sh, b_sh_nxt;
   logic [WIDTH-1:0] sum_sh, sum_sh_nxt;
   logic             c, c_nxt;
   logic             busy_nxt, done_nxt;
   logic [WIDTH-1:0] sum_out_nxt;
   logic             carry_out_nxt;

   // The adder cell: operates on the current LSBs and the registered carry.
   logic s_bit, c_new;
   assign s_bit = a_sh[0] ^ b_sh[0] ^ c;
   assign c_new = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         c         <= 1'b0;
         busy_out  <= 1'b0;
         done_out  <= 1'b0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         a_sh      <= a_sh_nxt;
         b_sh      <= b_sh_nxt;
         sum_sh    <= sum_sh_nxt;
         c         <= c_nxt;
         busy_out  <= busy_nxt;
         done_out  <= done_nxt;
         sum_out   <= sum_out_nxt;
         carry_out <= carry_out_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      a_sh_nxt      = a_sh;
      b_sh_nxt      = b_sh;
      sum_sh_nxt    = sum_sh;
      c_nxt         = c;
      done_nxt      = 1'b0;
      sum_out_nxt   = sum_out;
      carry_out_nxt = carry_out;

      case (state)
         IDLE: begin
            if (start_in) begin
               a_sh_nxt   = a_in;
               b_sh_nxt   = b_in;
               c_nxt      = cin_in;
               sum_sh_nxt = '0;
               cnt_nxt    = '0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_nxt   = a_sh >> 1;
            b_sh_nxt   = b_sh >> 1;
            c_nxt      = c_new;
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
            sum_sh_nxt = {s_bit, sum_sh[WIDTH-1:1]};
            cnt_nxt    = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               sum_out_nxt   = sum_sh_nxt;
               carry_out_nxt = c_new;
               done_nxt      = 1'b1;
               state_nxt     = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Registered busy tracks the state we are about to enter.
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk_in = 1'b0;
   logic         rst_n_in;
   logic         start_in;
   logic [W-1:0] a_in, b_in;
   logic         cin_in;
   logic         busy_out, done_out, carry_out;
   logic [W-1:0] sum_out;

   int total  = 0;
   int passed = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .start_in (start_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy_out (busy_out),
      .done_out (done_out),
      .sum_out  (sum_out),
      .carry_out(carry_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Full transaction: start, scramble inputs while shifting, then check
   // latency, result, done pulse width, busy length and result stability.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic ec, input string nm);
      logic [W-1:0] prev_s;
      logic         prev_c;
      int           lat;
      int           busy_n;
      bit           stable;
      bit           got;
      prev_s = sum_out;
      prev_c = carry_out;
      a_in = a; b_in = b; cin_in = ci; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
      check({nm, " busy_rise"}, busy_out, 1);
      busy_n = busy_out ? 1 : 0;
      stable = 1; got = 0; lat = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         tick();
         if (busy_out) busy_n++;
         if (done_out) begin
            got = 1;
            lat = i;
         end else if (sum_out !== prev_s || carry_out !== prev_c) begin
            stable = 0;
         end
      end
      check({nm, " latency"}, lat, W);
      check({nm, " hold_prev"}, stable, 1);
      check({nm, " sum"}, sum_out, es);
      check({nm, " carry"}, carry_out, ec);
      tick();
      check({nm, " done_width"}, done_out, 0);
      check({nm, " busy_fall"}, busy_out, 0);
      check({nm, " busy_len"}, busy_n, W + 1);
      check({nm, " sum_hold"}, sum_out, es);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra, rb;
      logic         rc;
      int           n;
      bit           got;
      bit           ok;
      int           lat;

      vecs[0] = '{a: 8'h3C, b: 8'h42, cin: 1'b0, s: 8'h7E, c: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
      vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, c: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};

      rst_n_in = 1'b0; start_in = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
      #12;
      check("rst sum", sum_out, 0);
      check("rst carry", carry_out, 0);
      check("rst busy", busy_out, 0);
      check("rst done", done_out, 0);
      tick();
      rst_n_in = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));
      end

      // Prior result 7E must stay visible through a following add.
      run_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "seed7e");
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after7e");

      // start held high: one accepted op every WIDTH+2 cycles.
      a_in = '0; b_in = '0; cin_in = 1'b0; start_in = 1'b1;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (done_out) got = 1;
      end
      check("hold first_done", got, 1);
      got = 0; n = 0;
      for (int i = 1; i <= 30 && !got; i++) begin
         tick();
         if (done_out) begin
            got = 1;
            n = i;
         end
      end
      check("hold interval", n, W + 2);
      start_in = 1'b0;
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         tick();
         if (!busy_out) ok = 1;
      end
      check("hold idle", ok, 1);
      check("hold sum", sum_out, 0);

      // Second request mid-SHIFT is dropped.
      a_in = 8'h10; b_in = 8'h20; cin_in = 1'b0; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      ok = 1; got = 0; lat = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         if (k == 3) begin
            start_in = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
         end else begin
            start_in = 1'b0;
         end
         tick();
         if (done_out) begin
            got = 1;
            lat = k;
         end else if (!busy_out) begin
            ok = 0;
         end
      end
      start_in = 1'b0;
      check("drop latency", lat, W);
      check("drop busy", ok, 1);
      check("drop sum", sum_out, 8'h30);
      check("drop carry", carry_out, 0);
      ok = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy_out || done_out) ok = 0;
      end
      check("drop no_second", ok, 1);

      // Reset mid-SHIFT aborts.
      a_in = 8'hFF; b_in = 8'h01; cin_in = 1'b0; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n_in = 1'b0;
      #1;
      check("abort sum", sum_out, 0);
      check("abort carry", carry_out, 0);
      check("abort busy", busy_out, 0);
      check("abort done", done_out, 0);
      tick();
      tick();
      rst_n_in = 1'b1;
      ok = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy_out || done_out || sum_out !== '0) ok = 0;
      end
      check("abort quiet", ok, 1);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "post_rst");

      // Random operands against plain arithmetic.
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         r  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         run_op(ra, rb, rc, r[W-1:0], r[W], $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
